dot_prod_acc: RTL and testbench

//   Streaming dot-product engine around the pipelined signed multiplier (mult_sgn_cnv).

---
 rtl/dot_prod_pkg.sv | 15 +
 rtl/mult_sgn_cnv.sv | 33 +++
 rtl/tag_delay_line.sv | 30 +++
 rtl/dot_prod_acc.sv | 139 +++++++++++++
 tb/tb_dot_prod_acc.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_prod_pkg.sv
// Shared types and helpers for the streaming dot-product engine.
package dot_prod_pkg;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  function automatic int mult_latency(input int width);
    return $clog2(width) + 2;
  endfunction

endpackage

// File: rtl/mult_sgn_cnv.sv
// Pipelined signed multiplier, no valid, no reset; product appears LAT edges after inputs are sampled.
module mult_sgn_cnv
  import dot_prod_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic [WIDTH-1:0]   i_x,
  input  logic [WIDTH-1:0]   i_y,
  output logic [2*WIDTH-1:0] o_p
);

  localparam int unsigned LAT = mult_latency(WIDTH);

  logic [WIDTH-1:0]          r_x;
  logic [WIDTH-1:0]          r_y;
  logic signed [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0]        r_p [LAT-1];

  assign w_prod = $signed(r_x) * $signed(r_y);

  always_ff @(posedge clk) begin
    r_x    <= i_x;
    r_y    <= i_y;
    r_p[0] <= w_prod;
    for (int unsigned i = 1; i < LAT - 1; i++) begin
      r_p[i] <= r_p[i-1];
    end
  end

  assign o_p = r_p[LAT-2];

endmodule

// File: rtl/tag_delay_line.sv
// Async-reset shift register carrying {valid,last} alongside the multiplier pipeline.
module tag_delay_line
  import dot_prod_pkg::*;
#(
  parameter int unsigned DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_line [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_line[i] <= '0;
      end
    end else begin
      r_line[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_line[i] <= r_line[i-1];
      end
    end
  end

  assign o_tag = r_line[DEPTH-1];

endmodule

// File: rtl/dot_prod_acc.sv
// Streaming dot-product accumulator driving an external pipelined multiplier.
// Define DOT_PROD_ACC_SAT_EN for saturating adds with a sticky per-vector overflow flag.
module dot_prod_acc
  import dot_prod_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_x,
  input  logic [WIDTH-1:0]     s_y,
  input  logic                 s_last,
  output logic [WIDTH-1:0]     mult_x,
  output logic [WIDTH-1:0]     mult_y,
  input  logic [2*WIDTH-1:0]   mult_p,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic                 m_ovf
);

  localparam int unsigned MULT_LAT = mult_latency(WIDTH);

  if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
    $error("dot_prod_acc: ACC_WIDTH must be at least 2*WIDTH");
  end

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic                        w_accept;
  tag_t                        w_tag_in;
  tag_t                        w_tail;
  tag_t                        r_stage_tag;
  logic signed [ACC_WIDTH-1:0] w_p_ext;
  logic signed [ACC_WIDTH-1:0] r_stage_p;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] r_m_data;

  assign s_ready  = (r_state == ACCUM);
  assign m_valid  = (r_state == HOLD);
  assign w_accept = s_valid && s_ready;
  assign mult_x   = w_accept ? s_x : '0;
  assign mult_y   = w_accept ? s_y : '0;
  assign w_tag_in = '{vld: w_accept, last: w_accept && s_last};
  assign w_p_ext  = ACC_WIDTH'($signed(mult_p));
  assign m_data   = r_m_data;

  tag_delay_line #(
    .DEPTH (MULT_LAT)
  ) u_tag_line (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept && s_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_stage_tag.vld && r_stage_tag.last) w_state_nxt = HOLD;
      HOLD:    if (m_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Tag and product are registered once more before the add so the adder sees a clean register pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_tag <= '0;
      r_stage_p   <= '0;
      r_acc       <= '0;
      r_m_data    <= '0;
    end else begin
      r_stage_tag <= w_tail;
      r_stage_p   <= w_p_ext;
      if (r_stage_tag.vld) begin
        if (r_stage_tag.last) begin
          r_m_data <= w_sum;
          r_acc    <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

`ifdef DOT_PROD_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] w_raw;
  logic                        w_add_ovf;
  logic                        r_ovf;
  logic                        r_m_ovf;

  always_comb begin
    w_raw     = r_acc + r_stage_p;
    w_add_ovf = (r_acc[ACC_WIDTH-1] == r_stage_p[ACC_WIDTH-1]) &&
                (w_raw[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    w_sum     = w_raw;
    if (w_add_ovf) begin
      w_sum = r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_m_ovf <= 1'b0;
    end else if (r_stage_tag.vld) begin
      if (r_stage_tag.last) begin
        r_m_ovf <= r_ovf || w_add_ovf;
        r_ovf   <= 1'b0;
      end else begin
        r_ovf <= r_ovf || w_add_ovf;
      end
    end
  end

  assign m_ovf = r_m_ovf;
`else
  assign w_sum = r_acc + r_stage_p;
  assign m_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dot_prod_acc.sv
// Scoreboard bench for dot_prod_acc wired to mult_sgn_cnv; a second 32-bit instance covers overflow.
module tb_dot_prod_acc;

  localparam int WIDTH   = 16;
  localparam int ACC_W   = 40;
  localparam int ACC_W2  = 32;
  localparam int LAT_EXP = 7;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             ovf;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid, s_ready, s_last, m_valid, m_ready, m_ovf;
  logic [WIDTH-1:0]   s_x, s_y, mult_x, mult_y;
  logic [2*WIDTH-1:0] mult_p;
  logic [ACC_W-1:0]   m_data;

  logic               s2_valid, s2_ready, s2_last, m2_valid, m2_ready, m2_ovf;
  logic [WIDTH-1:0]   s2_x, s2_y, mult2_x, mult2_y;
  logic [2*WIDTH-1:0] mult2_p;
  logic [ACC_W2-1:0]  m2_data;

  exp_t             sb[$];
  exp_t             exp_e;
  int               vx[$];
  int               vy[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  int               last_acc_edge = 0;
  bit               prev_mv = 1'b0;
  bit               post_hs = 1'b0;
  logic [ACC_W-1:0] hold_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot_prod_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .s_last(s_last), .mult_x(mult_x), .mult_y(mult_y), .mult_p(mult_p), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_ovf(m_ovf)
  );

  mult_sgn_cnv #(.WIDTH(WIDTH)) u_mult (
    .clk(clk), .i_x(mult_x), .i_y(mult_y), .o_p(mult_p)
  );

  dot_prod_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .s_valid(s2_valid), .s_ready(s2_ready), .s_x(s2_x), .s_y(s2_y),
    .s_last(s2_last), .mult_x(mult2_x), .mult_y(mult2_y), .mult_p(mult2_p), .m_valid(m2_valid),
    .m_ready(m2_ready), .m_data(m2_data), .m_ovf(m2_ovf)
  );

  mult_sgn_cnv #(.WIDTH(WIDTH)) u_mult32 (
    .clk(clk), .i_x(mult2_x), .i_y(mult2_y), .o_p(mult2_p)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic send_pair(input int x, input int y, input bit last);
    int tmo = 0;
    s_valid = 1'b1;
    s_x     = x[WIDTH-1:0];
    s_y     = y[WIDTH-1:0];
    s_last  = last;
    @(negedge clk);
    while (!s_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (!s_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_x     = '0;
    s_y     = '0;
  endtask

  task automatic send_vector(input int gap);
    longint sum = 0;
    exp_t   e;
    foreach (vx[i]) sum += longint'(vx[i]) * longint'(vy[i]);
    e.data = sum[ACC_W-1:0];
    e.ovf  = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < vx.size(); i++) begin
      send_pair(vx[i], vy[i], i == vx.size() - 1);
      if (i != vx.size() - 1) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int tmo = 0;
    while (sb.size() != 0 && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_m_valid", m_valid, 64'd0);
      prev_mv = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (post_hs) begin
        check("s_ready_after_hs", s_ready, 64'd1);
        post_hs = 1'b0;
      end
      if (s_valid && s_ready && s_last) last_acc_edge = cyc + 1;
      if (m_valid) begin
        check("s_ready_while_valid", s_ready, 64'd0);
        if (!prev_mv) begin
          check("latency", 64'(cyc - last_acc_edge), 64'(LAT_EXP));
          hold_data = m_data;
        end else begin
          check("data_stable", m_data, hold_data);
        end
        if (m_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            exp_e = sb.pop_front();
            check("m_data", m_data, exp_e.data);
            check("m_ovf", m_ovf, exp_e.ovf);
          end
          post_hs = 1'b1;
        end
      end
      prev_mv = m_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tmo;
    s_valid = 1'b0; s_last = 1'b0; s_x = '0; s_y = '0; m_ready = 1'b1;
    s2_valid = 1'b0; s2_last = 1'b0; s2_x = '0; s2_y = '0; m2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 64'd1);
    check("rst_m_valid", m_valid, 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_ovf", m_ovf, 64'd0);
    @(posedge clk);
    #1;

    vx = '{3, -2, 7}; vy = '{4, 5, -1};
    send_vector(0);
    wait_drain();

    vx = '{-32768}; vy = '{-32768};
    send_vector(0);
    wait_drain();

    vx = '{3, -2, 7}; vy = '{4, 5, -1};
    send_vector(3);
    wait_drain();

    vx = '{5, -9, 100, -1}; vy = '{-6, -9, 2, 32767};
    send_vector(1);
    wait_drain();

    m_ready = 1'b0;
    vx = '{3, -2, 7}; vy = '{4, 5, -1};
    send_vector(0);
    tmo = 0;
    while (!m_valid && tmo < 50) begin
      @(posedge clk);
      tmo++;
    end
    #1;
    check("t4_valid_seen", m_valid, 64'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    wait_drain();

    send_vector(0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    void'(sb.pop_back());
    vx = '{1}; vy = '{1};
    send_vector(0);
    wait_drain();

    s2_valid = 1'b1;
    s2_x = 16'h8000;
    s2_y = 16'h8000;
    for (int i = 0; i < 4; i++) begin
      s2_last = (i == 3);
      @(negedge clk);
      check("t6_s_ready", s2_ready, 64'd1);
      @(posedge clk);
      #1;
    end
    s2_valid = 1'b0;
    s2_last  = 1'b0;
    tmo = 0;
    @(negedge clk);
    while (!m2_valid && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    check("t6_valid", m2_valid, 64'd1);
`ifdef DOT_PROD_ACC_SAT_EN
    check("t6_m_data", m2_data, 64'h7FFF_FFFF);
    check("t6_m_ovf", m2_ovf, 64'd1);
`else
    check("t6_m_data", m2_data, 64'd0);
    check("t6_m_ovf", m2_ovf, 64'd0);
`endif
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
